// File: rtl/obtener_trama_pkg.sv
// Shared definitions for the delimited frame receiver: state encoding,
// abort cause codes and the ASCII constants used when decoding bytes.
package obtener_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECV     = 2'd1,
    ST_WAIT_END = 2'd2
  } state_t;

  localparam logic [1:0] ERR_SHORT    = 2'd0;
  localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
  localparam logic [1:0] ERR_LONG     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_9   = 8'h39;
  localparam logic [7:0] ASCII_Z   = 8'd122;
  localparam logic [7:0] BYTE_NULL = 8'h00;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

endpackage

// File: rtl/obtener_trama_timeout.sv
// Inter-byte watchdog. Down-counter reloaded on clr; expired flags the
// cycle in which TIMEOUT_CYC cycles have elapsed without a reload.
// A reload in the same cycle always suppresses expiry.
module trama_timeout #(
  parameter int unsigned TIMEOUT_CYC = 50_000
) (
  input  logic clk,
  input  logic init,
  input  logic clr,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LOAD = (TIMEOUT_CYC > 0) ? CW'(TIMEOUT_CYC - 1) : '0;

  logic [CW-1:0] cnt;

  // Reload on clr, otherwise count down toward terminal count while running.
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= LOAD;
    end else if (run && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (TIMEOUT_CYC != 0) && run && !clr && (cnt == '0);

endmodule

// File: rtl/obtener_trama.sv
// Delimited frame receiver: DELIM, N_BYTES payload bytes, DELIM.
// Commits the payload to trama on a good frame, otherwise pulses err with
// the cause. Bytes are only sampled on dato_valid; 8'h00 is padding.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_IDLE     | waiting for an opening delimiter
//   ST_RECV     | collecting payload bytes, fewer than N_BYTES so far
//   ST_WAIT_END | full payload held, expecting the closing delimiter
module obtener_trama
  import obtener_pkg::*;
#(
  parameter int unsigned          N_BYTES      = 6,
  parameter logic [7:0]           DELIM        = ASCII_Z,
  parameter bit                   CHECK_DIGITS = 1'b1,
  parameter int unsigned          TIMEOUT_CYC  = 50_000,
  parameter logic [8*N_BYTES-1:0] INIT_VAL     = {N_BYTES{8'h30}}
) (
  input  logic                   clk,
  input  logic                   init,
  input  logic [7:0]             dato,
  input  logic                   dato_valid,
  output logic [8*N_BYTES-1:0]   trama,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic                   busy,
  output logic [7:0]             frame_count
);

  localparam int unsigned IW = (N_BYTES > 1) ? $clog2(N_BYTES + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTES - 1);

  state_t               state;
  logic [IW-1:0]        index;
  logic [8*N_BYTES-1:0] buffer;
  logic [8*N_BYTES-1:0] buffer_shift;

  logic byte_live;
  logic is_delim;
  logic char_ok;
  logic tmo_clr;
  logic tmo_run;
  logic tmo_expired;

  // Padding bytes are invisible inside a frame, so they neither count nor
  // feed the watchdog.
  assign byte_live = dato_valid && (dato != BYTE_NULL);
  assign is_delim  = (dato == DELIM);
  assign char_ok   = !CHECK_DIGITS || is_digit(dato);

  // First byte lands in the low byte; each new byte enters at the top.
  if (N_BYTES > 1) begin : g_shift
    assign buffer_shift = {dato, buffer[8*N_BYTES-1:8]};
  end else begin : g_single
    assign buffer_shift = dato;
  end

  // Any byte that is acted upon inside a frame restarts the watchdog and
  // thereby wins against an expiry in the same cycle.
  assign tmo_clr = (state == ST_IDLE) ? (dato_valid && is_delim) : byte_live;
  assign tmo_run = (state != ST_IDLE);

  trama_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .init    (init),
    .clr     (tmo_clr),
    .run     (tmo_run),
    .expired (tmo_expired)
  );

  // Frame FSM with registered outputs; done/err are single-cycle pulses.
  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state       <= ST_IDLE;
      index       <= '0;
      buffer      <= '0;
      trama       <= INIT_VAL;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_SHORT;
      busy        <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dato_valid && is_delim) begin
            state  <= ST_RECV;
            index  <= '0;
            buffer <= '0;
            busy   <= 1'b1;
          end
        end
        ST_RECV: begin
          if (byte_live) begin
            if (is_delim) begin
              // Early delimiter is taken as the opening of a fresh frame.
              err      <= 1'b1;
              err_code <= ERR_SHORT;
              index    <= '0;
              buffer   <= '0;
            end else if (!char_ok) begin
              err      <= 1'b1;
              err_code <= ERR_BAD_CHAR;
              state    <= ST_IDLE;
              busy     <= 1'b0;
            end else begin
              buffer <= buffer_shift;
              index  <= index + IW'(1);
              if (index == LAST_IDX) begin
                state <= ST_WAIT_END;
              end
            end
          end else if (tmo_expired) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end
        end
        ST_WAIT_END: begin
          if (byte_live) begin
            if (is_delim) begin
              trama       <= buffer;
              done        <= 1'b1;
              frame_count <= frame_count + 8'd1;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_LONG;
            end
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (tmo_expired) begin
            err      <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= ST_IDLE;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obtener_trama.sv
// Bench for obtener_trama: vector table for the basic frame outcomes, a
// frame-level reference model checked every cycle, directed timeout and
// reset sequences, and randomized byte streams.
module tb_obtener_trama;

  localparam int NB = 6;
  localparam int TO = 50000;
  localparam logic [47:0] T0 = 48'h303030303030;
  localparam logic [47:0] TA = 48'h363534333231;
  localparam logic [47:0] TB = 48'h323130393837;

  logic        clk = 1'b0;
  logic        init;
  logic [7:0]  dato;
  logic        dato_valid;
  logic [47:0] trama;
  logic        done, err, busy;
  logic [1:0]  err_code;
  logic [7:0]  frame_count;

  logic [47:0] trama_s;
  logic        done_s, err_s, busy_s;
  logic [1:0]  err_code_s;
  logic [7:0]  frame_count_s;

  obtener_trama u_dut (
    .clk(clk), .init(init), .dato(dato), .dato_valid(dato_valid),
    .trama(trama), .done(done), .err(err), .err_code(err_code),
    .busy(busy), .frame_count(frame_count)
  );

  obtener_trama #(.TIMEOUT_CYC(5)) u_dut_short (
    .clk(clk), .init(init), .dato(dato), .dato_valid(dato_valid),
    .trama(trama_s), .done(done_s), .err(err_s), .err_code(err_code_s),
    .busy(busy_s), .frame_count(frame_count_s)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: tracks the frame as a list of payload bytes.
  bit          m_in_frame;
  logic [7:0]  m_q[$];
  int          m_idle;
  logic [47:0] m_trama;
  int          m_count;
  bit          m_done, m_err;
  logic [1:0]  m_code;

  function automatic void m_reset();
    m_in_frame = 0; m_q.delete(); m_idle = 0; m_trama = T0;
    m_count = 0; m_done = 0; m_err = 0; m_code = 2'd0;
  endfunction

  function automatic void m_abort(input logic [1:0] code, input bit leave);
    m_err = 1; m_code = code;
    if (leave) m_in_frame = 0;
  endfunction

  function automatic void m_step(input bit v, input logic [7:0] d);
    m_done = 0; m_err = 0;
    if (!m_in_frame) begin
      if (v && d == 8'd122) begin
        m_in_frame = 1; m_q.delete(); m_idle = 0;
      end
    end else if (v && d != 8'h00) begin
      m_idle = 0;
      if (d == 8'd122) begin
        if (m_q.size() < NB) begin
          m_abort(2'd0, 0); m_q.delete();
        end else begin
          m_trama = '0;
          for (int i = 0; i < NB; i++) m_trama[8*i +: 8] = m_q[i];
          m_done = 1; m_count = (m_count + 1) % 256; m_in_frame = 0;
        end
      end else if (m_q.size() == NB) begin
        m_abort(2'd2, 1);
      end else if (d < 8'h30 || d > 8'h39) begin
        m_abort(2'd1, 1);
      end else begin
        m_q.push_back(d);
      end
    end else begin
      m_idle++;
      if (m_idle == TO) m_abort(2'd3, 1);
    end
  endfunction

  task automatic tick(input bit v, input logic [7:0] d);
    dato_valid = v;
    dato = d;
    @(posedge clk);
    m_step(v, d);
    #1;
    chk("done", done, m_done);
    chk("err", err, m_err);
    chk("err_code", err_code, m_code);
    chk("busy", busy, m_in_frame);
    chk("trama", trama, m_trama);
    chk("frame_count", frame_count, m_count[7:0]);
  endtask

  typedef struct {
    bit          v;
    logic [7:0]  d;
    bit          e_done;
    bit          e_err;
    logic [1:0]  e_code;
    bit          e_busy;
    logic [47:0] e_trama;
    logic [7:0]  e_count;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit v, input logic [7:0] d, input bit dn, input bit er,
                              input logic [1:0] cd, input bit bz, input logic [47:0] tr,
                              input logic [7:0] ct);
    vec_t r;
    r.v = v; r.d = d; r.e_done = dn; r.e_err = er; r.e_code = cd;
    r.e_busy = bz; r.e_trama = tr; r.e_count = ct;
    tbl.push_back(r);
  endfunction

  function automatic logic [7:0] rnd_byte();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return 8'd122;
    if (r < 7) return 8'h30 + 8'($urandom_range(0, 9));
    if (r == 7) return 8'h00;
    if (r == 8) return 8'h41 + 8'($urandom_range(0, 25));
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    // bad character, ignored strobes
    add(1, "z", 0, 0, 0, 1, T0, 0);
    add(1, "1", 0, 0, 0, 1, T0, 0);
    add(1, "A", 0, 1, 1, 0, T0, 0);
    add(0, "z", 0, 0, 1, 0, T0, 0);
    // good frame with padding byte inside
    add(1, "z", 0, 0, 1, 1, T0, 0);
    add(1, "1", 0, 0, 1, 1, T0, 0);
    add(1, "2", 0, 0, 1, 1, T0, 0);
    add(1, "3", 0, 0, 1, 1, T0, 0);
    add(1, 8'h00, 0, 0, 1, 1, T0, 0);
    add(1, "4", 0, 0, 1, 1, T0, 0);
    add(1, "5", 0, 0, 1, 1, T0, 0);
    add(1, "6", 0, 0, 1, 1, T0, 0);
    add(1, "z", 1, 0, 1, 0, TA, 1);
    add(1, "1", 0, 0, 1, 0, TA, 1);
    // short frame restarts, then good frame
    add(1, "z", 0, 0, 1, 1, TA, 1);
    add(1, "1", 0, 0, 1, 1, TA, 1);
    add(1, "2", 0, 0, 1, 1, TA, 1);
    add(1, "z", 0, 1, 0, 1, TA, 1);
    add(1, "7", 0, 0, 0, 1, TA, 1);
    add(1, "8", 0, 0, 0, 1, TA, 1);
    add(1, "9", 0, 0, 0, 1, TA, 1);
    add(1, "0", 0, 0, 0, 1, TA, 1);
    add(1, "1", 0, 0, 0, 1, TA, 1);
    add(1, "2", 0, 0, 0, 1, TA, 1);
    add(1, "z", 1, 0, 0, 0, TB, 2);
    // too long
    add(1, "z", 0, 0, 0, 1, TB, 2);
    add(1, "1", 0, 0, 0, 1, TB, 2);
    add(1, "2", 0, 0, 0, 1, TB, 2);
    add(1, "3", 0, 0, 0, 1, TB, 2);
    add(1, "4", 0, 0, 0, 1, TB, 2);
    add(1, "5", 0, 0, 0, 1, TB, 2);
    add(1, "6", 0, 0, 0, 1, TB, 2);
    add(1, "7", 0, 1, 2, 0, TB, 2);

    init = 1'b0; dato_valid = 1'b0; dato = 8'h00;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trama", trama, T0);
    chk("rst_busy", busy, 0);
    chk("rst_count", frame_count, 0);
    init = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].v, tbl[i].d);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].e_done);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].e_err);
      chk($sformatf("tbl%0d_code", i), err_code, tbl[i].e_code);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("tbl%0d_trama", i), trama, tbl[i].e_trama);
      chk($sformatf("tbl%0d_count", i), frame_count, tbl[i].e_count);
    end

    // short-timeout instance: byte arriving on the expiry cycle wins,
    // padding does not restart the watchdog
    tick(1, "z");
    tick(1, "1");
    repeat (4) tick(0, 8'h00);
    tick(1, "2");
    chk("tmo5_bytewins_err", err_s, 0);
    chk("tmo5_bytewins_busy", busy_s, 1);
    tick(1, 8'h00);
    chk("tmo5_pad1_err", err_s, 0);
    tick(1, 8'h00);
    chk("tmo5_pad2_err", err_s, 0);
    tick(0, 8'h00);
    tick(0, 8'h00);
    chk("tmo5_early_err", err_s, 0);
    tick(0, 8'h00);
    chk("tmo5_err", err_s, 1);
    chk("tmo5_code", err_code_s, 3);
    chk("tmo5_busy", busy_s, 0);

    // default watchdog fires exactly TO cycles after the last byte
    tick(1, "z");
    tick(1, "1");
    for (int k = 1; k <= TO; k++) begin
      tick(0, 8'h00);
      if (k == TO - 1) chk("tmo_early", err, 0);
      if (k == TO) begin
        chk("tmo_at_limit_err", err, 1);
        chk("tmo_at_limit_code", err_code, 3);
      end
    end

    // reset mid-frame
    tick(1, "z");
    tick(1, "1");
    tick(1, "2");
    init = 1'b0;
    #1;
    m_reset();
    chk("arst_trama", trama, T0);
    chk("arst_busy", busy, 0);
    chk("arst_err", err, 0);
    chk("arst_code", err_code, 0);
    chk("arst_count", frame_count, 0);
    @(posedge clk);
    #1;
    chk("arst_err_hold", err, 0);
    init = 1'b1;
    tick(1, "5");
    tick(1, "z");

    // 256 good random frames wrap the counter back to zero
    m_reset();
    init = 1'b0;
    #1;
    init = 1'b1;
    for (int f = 0; f < 256; f++) begin
      tick(1, "z");
      for (int b = 0; b < NB; b++) tick(1, 8'h30 + 8'($urandom_range(0, 9)));
      tick(1, "z");
    end
    chk("wrap_count", frame_count, 0);

    // random stream
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 3) != 0, rnd_byte());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/obtener_trama.md
OBTENER_TRAMA -- requirements
Module: obtener_trama

Interface
REQ-001 SHALL have parameter N_BYTES, default 6, payload bytes per frame (range 1..16).
REQ-002 SHALL have parameter DELIM, default 8'd122 ('z'), start/end delimiter byte.
REQ-003 SHALL have parameter CHECK_DIGITS, default 1, when 1 only ASCII '0'..'9' accepted as payload.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 50_000, max clk cycles between accepted bytes inside a frame; 0 disables timeout.
REQ-005 SHALL have parameter INIT_VAL, default N_BYTES copies of 8'h30, reset value of trama.
REQ-006 clk  input  1  single system clock, all logic on rising edge.
REQ-007 init  input  1  reset, asynchronous, active-low.
REQ-008 dato  input  8  received byte.
REQ-009 dato_valid  input  1  one-cycle strobe, dato sampled only when high.
REQ-010 trama  output  8*N_BYTES  last good frame payload.
REQ-011 done  output  1  one-cycle pulse on frame commit.
REQ-012 err  output  1  one-cycle pulse on frame abort.
REQ-013 err_code  output  2  abort cause, held until next err: 0 SHORT, 1 BAD_CHAR, 2 LONG, 3 TIMEOUT.
REQ-014 busy  output  1  high while state is not IDLE.
REQ-015 frame_count  output  8  number of committed frames, wraps 255->0.

Function
REQ-016 SHALL implement FSM with states IDLE, RECV, WAIT_END; bytes with dato_valid low are ignored in all states.
REQ-017 IDLE: valid DELIM -> RECV, index cleared, shift buffer cleared; any other byte ignored.
REQ-018 RECV/WAIT_END: valid 8'h00 ignored (not counted, timeout not restarted).
REQ-019 RECV: valid DELIM before N_BYTES payload bytes -> err SHORT, stay RECV as new frame start, index cleared.
REQ-020 RECV: CHECK_DIGITS=1 and byte outside 8'h30..8'h39 (and not DELIM/00) -> err BAD_CHAR, -> IDLE.
REQ-021 RECV: accepted byte shifts in as buffer = {dato, buffer[8*N_BYTES-1:8]}; first byte ends in bits [7:0], last in top byte.
REQ-022 RECV: accepting byte number N_BYTES -> WAIT_END.
REQ-023 WAIT_END: valid DELIM -> trama loaded from buffer, done pulse, frame_count+1, -> IDLE; all in same cycle after the strobe edge (latency 1 clk).
REQ-024 WAIT_END: valid non-DELIM, non-00 byte -> err LONG, -> IDLE; trama unchanged.
REQ-025 Timeout counter SHALL clear on entry to RECV and on each accepted byte, count every cycle in RECV/WAIT_END; reaching TIMEOUT_CYC -> err TIMEOUT, -> IDLE.
REQ-026 Timeout and valid byte in same cycle: byte wins, timeout not flagged.
REQ-027 trama SHALL change only on commit; aborted frames never alter trama or frame_count.
REQ-028 done and err SHALL never assert in the same cycle.
REQ-029 Commit DELIM does not start a new frame; next frame needs a further DELIM.

Reset
REQ-030 init low SHALL asynchronously force: state IDLE, trama=INIT_VAL, done=0, err=0, err_code=0, busy=0, frame_count=0, buffer=0, index=0, timeout counter=0.
REQ-031 init low mid-frame SHALL discard the partial frame with no err pulse.
REQ-032 After init rises, first action is on the next valid strobe; no reception in the release cycle's edge is lost except bytes before it.

Structure
REQ-033 Shared package obtener_pkg SHALL hold FSM state encoding, err_code constants, and ASCII constants 8'h30/8'h39/8'd122.
REQ-034 Timeout counter SHALL be sub-module trama_timeout (params TIMEOUT_CYC; ports clk, init, clr, run, expired).
REQ-035 No derived clocks; all rate control by dato_valid strobe.

Verification
REQ-036 Defaults; strobe 'z','1','2','3','4','5','6','z' -> done 1 cycle, trama=48'h363534333231, frame_count=1.
REQ-037 'z','1','2','z' -> err, err_code=0, busy stays 1; then '1'..'6','z' -> done, trama updated.
REQ-038 'z','1','A' -> err, err_code=1, busy=0, trama=48'h303030303030.
REQ-039 'z','1'..'6','7' -> err_code=2; 'z','1', then 50_000 idle cycles -> err_code=3 exactly at cycle 50_000.
REQ-040 init low after 'z','1','2' -> outputs at reset values immediately, no err; 256 good frames -> frame_count=0.
